// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: per-stage payload structs packed into pipe_stage_reg,
// their canonical bubble (NOP) values and a small occupancy helper.
// Stage registers are built with or without a skid buffer via PIPE_STAGE_SKID_EN.
package pipe_pkg;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluAnd  = 4'd2,
        AluOr   = 4'd3,
        AluXor  = 4'd4,
        AluSll  = 4'd5,
        AluSrl  = 4'd6,
        AluSra  = 4'd7,
        AluSlt  = 4'd8,
        AluSltu = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        MemByte = 2'd0,
        MemHalf = 2'd1,
        MemWord = 2'd2
    } mem_size_e;

    // Decode -> execute payload.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        alu_op_e     alu_op;
        logic        use_imm;
        logic        mem_re;
        logic        mem_we;
        mem_size_e   mem_size;
        logic        reg_we;
        logic [4:0]  rd;
    } id_ex_t;

    // Execute -> memory payload.
    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_data;
        logic        mem_re;
        logic        mem_we;
        mem_size_e   mem_size;
        logic        reg_we;
        logic [4:0]  rd;
    } ex_mem_t;

    // Memory -> writeback payload.
    typedef struct packed {
        logic [31:0] wb_data;
        logic        reg_we;
        logic [4:0]  rd;
    } mem_wb_t;

    // All-zero payloads clear every write enable, so a bubble is a NOP in every stage.
    localparam id_ex_t  IdExBubble  = '0;
    localparam ex_mem_t ExMemBubble = '0;
    localparam mem_wb_t MemWbBubble = '0;

    // Number of live entries held by a stage (main register plus optional skid).
    function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
        return {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready/data handshake bundle between two pipeline stages.
// The producer uses the master modport, the consumer the slave modport.
// Identical in both PIPE_STAGE_SKID_EN builds.
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W = 32
);

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );

endinterface

// File: rtl/pipe_skid_buf.sv
// Skid register plus the steering mux that selects what the main register loads.
// Only built when PIPE_STAGE_SKID_EN is defined; ready_o comes straight from a flop so
// downstream hazard logic never reaches the upstream stage combinationally.
`ifdef PIPE_STAGE_SKID_EN
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W     = 32,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              main_valid_i,
    input  logic              main_drain_i,
    output logic              ready_o,
    output logic              skid_valid_o,
    output logic              main_load_o,
    output logic [DATA_W-1:0] main_data_o
);

    logic              skid_valid_q;
    logic [DATA_W-1:0] skid_data_q;
    logic              accept;
    logic              to_skid;
    logic              from_skid;

    assign ready_o      = ~skid_valid_q;
    assign skid_valid_o = skid_valid_q;

    // Flush drops the offered beat even though ready_o may be high.
    assign accept    = valid_i & ~skid_valid_q & ~flush_i;
    assign to_skid   = accept & main_valid_i & ~main_drain_i;
    assign from_skid = skid_valid_q & main_drain_i;

    // Steering: a full skid always refills main first, so order is preserved.
    always_comb begin
        main_load_o = 1'b0;
        main_data_o = data_i;
        if (skid_valid_q) begin
            main_load_o = main_drain_i;
            main_data_o = skid_data_q;
        end else if (!main_valid_i || main_drain_i) begin
            main_load_o = accept;
        end
    end

    // Skid register: captures the one beat accepted while main is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= BUBBLE_VAL;
        end else if (flush_i) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= BUBBLE_VAL;
        end else if (to_skid) begin
            skid_valid_q <= 1'b1;
            skid_data_q  <= data_i;
        end else if (from_skid) begin
            skid_valid_q <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: one packed payload with valid/ready handshake, flush-to-bubble
// and back-pressure. Define PIPE_STAGE_SKID_EN to add a skid register that makes ready
// a pure flop output (occupancy 0..2); otherwise ready is combinational from downstream.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W     = 32,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    pipe_stage_reg_if.slave  up,
    pipe_stage_reg_if.master dn,
    output logic [1:0]       occ_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              drain;
    logic              ready;
    logic              skid_valid;
    logic              main_load;
    logic [DATA_W-1:0] main_data;

    // An output presented during flush still counts as taken; downstream decides.
    assign drain = valid_q & dn.ready;

`ifdef PIPE_STAGE_SKID_EN
    pipe_skid_buf #(
        .DATA_W     (DATA_W),
        .BUBBLE_VAL (BUBBLE_VAL)
    ) u_skid (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush_i),
        .valid_i      (up.valid),
        .data_i       (up.data),
        .main_valid_i (valid_q),
        .main_drain_i (drain),
        .ready_o      (ready),
        .skid_valid_o (skid_valid),
        .main_load_o  (main_load),
        .main_data_o  (main_data)
    );
`else
    assign skid_valid = 1'b0;
    assign ready      = ~valid_q | dn.ready;
    assign main_load  = up.valid & ready & ~flush_i;
    assign main_data  = up.data;
`endif

    assign up.ready = ready;
    assign dn.valid = valid_q;
    assign dn.data  = data_q;
    assign occ_o    = occ_count(valid_q, skid_valid);

    // Main register: flush dominates, then load, then drain to empty (data held).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= BUBBLE_VAL;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            data_q  <= BUBBLE_VAL;
        end else if (main_load) begin
            valid_q <= 1'b1;
            data_q  <= main_data;
        end else if (drain) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register carrying an arbitrary-width payload between two core stages (ID/EX, EX/MEM, MEM/WB) with a valid/ready handshake, flush-to-bubble and back-pressure. It replaces the per-stage hand-listed register banks: stages pack their control and data fields into one vector. An optional skid buffer registers `ready_o` to break the combinational ready path from downstream hazard logic.

## Interface
- `DATA_W`, 32: payload width in bits; must be ≥1.
- `BUBBLE_VAL`, `'0`: payload value driven on flush/reset. All-zero means no register or memory write, i.e. a NOP.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `flush_i`  in  1  kill all held entries; higher priority than every other input
- `valid_i`  in  1  upstream has a payload
- `ready_o`  out  1  stage can accept this cycle
- `data_i`  in  DATA_W  upstream payload
- `valid_o`  out  1  payload on `data_o` is live
- `ready_i`  in  1  downstream accepts this cycle (low = stall)
- `data_o`  out  DATA_W  registered payload
- `occ_o`  out  2  entries held (0..1, or 0..2 with skid)

## Operation
- Transfer in: `valid_i & ready_o`. Transfer out: `valid_o & ready_i`. Both are sampled on the rising edge of `clk`.
- Main register (`valid_q`, `data_q`) always drives `valid_o` and `data_o`.
- Without skid:
  - `ready_o = !valid_q | ready_i`, combinational.
  - On accept, `data_q <= data_i` and `valid_q <= 1`.
  - On drain without a new accept, `valid_q <= 0` and `data_q` holds its value.
- With skid, a second register (`skid_v`, `skid_d`) is added:
  - `ready_o = !skid_v`, taken directly from the flop.
  - Accept while the main register is full and not draining: write into skid.
  - Main draining while skid is full: skid moves to main, and skid is freed.
  - Main draining while skid is empty: main loads the accepted input, or goes invalid if there is none.
  - Order is always preserved; skid is never bypassed ahead of main.
- Flush:
  - Next edge: all valid bits are 0 and all payload registers equal `BUBBLE_VAL`.
  - An input offered in the flush cycle is dropped, even if `ready_o` was 1.
  - An output presented in the flush cycle is still counted as taken if `ready_i` = 1. Downstream owns that decision.
- Stall: `ready_i` = 0 with `valid_o` = 1 holds `data_o` and `valid_o` stable until taken (AXI-style rule).
- `occ_o` = `valid_q + skid_v`; it is never 2 without skid.

## Timing
- Reset (async assert, sync release): `valid_o` = 0, `data_o` = `BUBBLE_VAL`, `occ_o` = 0, skid empty, `ready_o` = 1.
- Reset asserted mid-transfer aborts the transfer immediately; no partial payload remains.
- Latency: `data_i` accepted at edge N appears on `data_o` after edge N.
- Throughput: 1 transfer/cycle sustained in both configurations when `ready_i` = 1.
- Simultaneous accept and drain, main full, skid empty: main updates to new data; `occ_o` stays 1.
- Skid full and `ready_i` = 1: after the edge, main = old skid, skid empty, `ready_o` = 1. The input offered in that cycle was refused because `ready_o` was 0.
- With skid, the worst-case stall response is one extra accepted beat beyond the stall edge; it is held in skid.
- Flush and reset both dominate any simultaneous stall or accept.

## Configuration
- `PIPE_STAGE_SKID_EN` defined:
  - Skid register present; `ready_o` is a pure flop output.
  - `occ_o` ranges 0..2.
- `PIPE_STAGE_SKID_EN` undefined:
  - Single register; `ready_o` is combinational from `ready_i`.
  - Skid logic is absent; `occ_o[1]` is tied to 0.
- Port list is identical in both builds.

## Structure
- Shared package `pipe_pkg` holds:
  - packed struct typedefs per stage (`id_ex_t`, `ex_mem_t`, `mem_wb_t`), so instantiations use `$bits(id_ex_t)` as `DATA_W`;
  - the canonical bubble constants per stage.
- One sub-module, `pipe_skid_buf`, under `PIPE_STAGE_SKID_EN`: the skid register plus its steering mux. The top level keeps the main register, flush and occupancy logic.

## Test plan
All scenarios use `DATA_W` = 32 and `BUBBLE_VAL` = 0.
- **Reset:** `rst_n` low mid-stream with `valid_q` = 1 → `valid_o` = 0, `data_o` = 0, `ready_o` = 1, `occ_o` = 0 asynchronously.
- **Streaming:** 0x1,0x2,0x3,0x4 on back-to-back cycles, `ready_i` = 1 → same sequence on `data_o` one cycle later; no gaps.
- **Stall (skid build):** stream 0xA,0xB,0xC, with `ready_i` = 0 at the edge where 0xA is output.
  - 0xA is held, 0xB goes to skid, `ready_o` = 0, `occ_o` = 2.
  - On release, the output order is 0xA,0xB,0xC with no loss or duplication.
- **Stall (no-skid build):** same stimulus as the stall scenario → `ready_o` drops in the stall cycle; 0xB is held upstream; same output order.
- **Flush:** `flush_i` with `occ_o` = 2 and `valid_i` = 1 offering 0xDEAD → next cycle `valid_o` = 0, `data_o` = 0, `occ_o` = 0; 0xDEAD never appears.
- **Random stress:** random `valid_i`/`ready_i`/`flush_i` at 30 % over 10k cycles, checked against a scoreboard FIFO model → in-order delivery, no loss except flushed beats, and `data_o` stable whenever stalled.
